// File: rtl/rot_sched.sv
`default_nettype none
// ============================================================================
// Module   : rot_sched
// Purpose  : Round-robin time-sharing of one external 8-bit barrel rotator
//            among NREQ requesters; iterates the rotator once per cycle.
// Revision : 1.0
// ============================================================================
module rot_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [3*NREQ-1:0] req_ctr,
  input  logic [NREQ-1:0]   req_dir,
  input  logic [4*NREQ-1:0] req_steps,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy,
  output logic [7:0]        rot_data,
  output logic [2:0]        rot_ctr,
  output logic              rot_dir,
  input  logic [7:0]        rot_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [7:0]     r_work;
  logic [3:0]     r_cnt;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_last;
  logic [7:0]     r_rot_data;
  logic [2:0]     r_rot_ctr;
  logic           r_rot_dir;

  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_grant;
  logic [7:0]      w_data;
  logic [2:0]      w_ctr;
  logic            w_dir;
  logic [3:0]      w_steps;

  // Search upward from the requester after the last grant, wrapping at NREQ.
  always_comb begin
    logic [IDW-1:0] cand;
    cand    = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!w_found && req_valid[cand]) begin
        w_found = 1'b1;
        w_idx   = cand;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (r_state == IDLE && w_found)
      w_grant[w_idx] = 1'b1;
  end

  always_comb begin
    w_data  = req_data[8*w_idx +: 8];
    w_ctr   = req_ctr[3*w_idx +: 3];
    w_dir   = req_dir[w_idx];
    w_steps = req_steps[4*w_idx +: 4];
  end

  // rot_* registers shadow the working operand only while passes remain,
  // so they keep the last value actually presented to the rotator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_work     <= 8'h00;
      r_cnt      <= 4'd0;
      r_id       <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_rot_data <= 8'h00;
      r_rot_ctr  <= 3'd0;
      r_rot_dir  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_work <= w_data;
            r_cnt  <= w_steps;
            r_id   <= w_idx;
            r_last <= w_idx;
            if (w_steps != 4'd0) begin
              r_state    <= RUN;
              r_rot_data <= w_data;
              r_rot_ctr  <= w_ctr;
              r_rot_dir  <= w_dir;
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          r_work <= rot_out;
          r_cnt  <= r_cnt - 4'd1;
          if (r_cnt == 4'd1)
            r_state <= DONE;
          else
            r_rot_data <= rot_out;
        end
        DONE: begin
          if (resp_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign resp_valid = (r_state == DONE);
  assign resp_data  = r_work;
  assign resp_id    = r_id;
  assign busy       = (r_state != IDLE);
  assign rot_data   = r_rot_data;
  assign rot_ctr    = r_rot_ctr;
  assign rot_dir    = r_rot_dir;

endmodule
`default_nettype wire

// File: tb/tb_rot_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_sched
// Purpose  : Randomized scoreboard bench for rot_sched with an external rotator.
// Revision : 1.0
// ============================================================================
module tb_rot_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_data;
  logic [3*NREQ-1:0] req_ctr;
  logic [NREQ-1:0]   req_dir;
  logic [4*NREQ-1:0] req_steps;
  logic              resp_valid;
  logic              resp_ready;
  logic [7:0]        resp_data;
  logic [IDW-1:0]    resp_id;
  logic              busy;
  logic [7:0]        rot_data;
  logic [2:0]        rot_ctr;
  logic              rot_dir;
  logic [7:0]        rot_out;

  rot_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_ctr(req_ctr), .req_dir(req_dir), .req_steps(req_steps),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy),
    .rot_data(rot_data), .rot_ctr(rot_ctr), .rot_dir(rot_dir), .rot_out(rot_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared combinational rotator, bit by bit.
  function automatic logic [7:0] ext_rot(input logic [7:0] d, input logic [2:0] c, input logic dl);
    logic [7:0] o;
    for (int i = 0; i < 8; i++)
      o[i] = dl ? d[(i + 8 - int'(c)) % 8] : d[(i + int'(c)) % 8];
    return o;
  endfunction
  assign rot_out = ext_rot(rot_data, rot_ctr, rot_dir);

  // Net effect of a whole job: one rotation by (steps*ctr) mod 8.
  function automatic logic [7:0] job_result(input logic [7:0] d, input int c, input logic dl, input int s);
    logic [15:0] t;
    int amt;
    amt = (s * c) % 8;
    t = {d, d};
    if (dl) begin
      t = t << amt;
      return t[15:8];
    end
    t = t >> amt;
    return t[7:0];
  endfunction

  typedef struct {
    logic [7:0]     data;
    logic [IDW-1:0] id;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             n_vec = 0;
  int             n_err = 0;
  int             cyc = 0;
  bit             m_busy = 1'b0;
  int             m_last = NREQ - 1;
  bit             in_resp = 1'b0;
  logic [7:0]     snap_d;
  logic [IDW-1:0] snap_id;
  logic [7:0]     j_data [NREQ];
  logic [2:0]     j_ctr  [NREQ];
  logic           j_dir  [NREQ];
  logic [3:0]     j_steps[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_data[8*i +: 8]  = j_data[i];
      req_ctr[3*i +: 3]   = j_ctr[i];
      req_dir[i]          = j_dir[i];
      req_steps[4*i +: 4] = j_steps[i];
    end
  endtask

  task automatic new_job(input int i);
    j_data[i]  = 8'($urandom);
    j_ctr[i]   = 3'($urandom_range(0, 7));
    j_dir[i]   = 1'($urandom_range(0, 1));
    j_steps[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    req_valid[i] = 1'b1;
  endtask

  task automatic set_job(input int i, input logic [7:0] d, input logic [2:0] c,
                         input logic dl, input logic [3:0] s);
    j_data[i] = d; j_ctr[i] = c; j_dir[i] = dl; j_steps[i] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_rot_data", rot_data, 0);
    check("rst_rot_ctr", rot_ctr, 0);
    check("rst_rot_dir", rot_dir, 0);
  endtask

  // One clock: model arbitration at the negedge, then update stimulus after the edge.
  task automatic cycle_step(input bit gen);
    logic [NREQ-1:0] exp_g, hs;
    int w;
    @(negedge clk);
    exp_g = '0;
    w = -1;
    if (!m_busy)
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
    if (w >= 0) exp_g[w] = 1'b1;
    check("grant", req_ready, exp_g);
    check("busy", busy, m_busy);
    if (w >= 0) begin
      exp_t e;
      e.data = job_result(j_data[w], int'(j_ctr[w]), j_dir[w], int'(j_steps[w]));
      e.id   = IDW'(w);
      e.due  = cyc + 1 + int'(j_steps[w]);
      sb.push_back(e);
      m_last = w;
      m_busy = 1'b1;
    end
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) req_valid[i] = 1'b0;
      else if (gen && req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      if (gen && !req_valid[i] && !hs[i] && $urandom_range(0, 2) == 0) new_job(i);
    end
    resp_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    drive();
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    n = 0;
    while ((m_busy || sb.size() != 0) && n < 300) begin
      cycle_step(1'b0);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each response handshake.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", resp_valid, 0);
      end else begin
        if (!in_resp) begin
          in_resp = 1'b1;
          snap_d  = resp_data;
          snap_id = resp_id;
          check("latency", cyc, sb[0].due);
        end else begin
          check("hold_data", resp_data, snap_d);
          check("hold_id", resp_id, snap_id);
        end
        if (resp_ready) begin
          exp_t e;
          e = sb.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_id", resp_id, e.id);
          in_resp = 1'b0;
          @(posedge clk);
          m_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    req_valid = '0; resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      j_data[i] = 8'h00; j_ctr[i] = 3'd0; j_dir[i] = 1'b0; j_steps[i] = 4'd0;
    end
    drive();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Worked examples, granted 0, 1, 2 in round-robin order.
    set_job(1, 8'h01, 3'd2, 1'b0, 4'd1);
    set_job(0, 8'h81, 3'd1, 1'b1, 4'd3);
    set_job(2, 8'hA5, 3'd5, 1'b0, 4'd0);
    drive();
    repeat (30) cycle_step(1'b0);

    repeat (2000) cycle_step(1'b1);
    drain();

    // Abandon a long job mid-run.
    set_job(2, 8'h3C, 3'd3, 1'b1, 4'd15);
    drive();
    repeat (5) cycle_step(1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    sb.delete();
    m_busy = 1'b0; m_last = NREQ - 1; in_resp = 1'b0;
    req_valid = '0;
    set_job(0, 8'h11, 3'd1, 1'b0, 4'd1);
    set_job(3, 8'h22, 3'd2, 1'b1, 4'd2);
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    // Model already saw requester 0 transfer; account for it before resuming.
    begin
      exp_t e;
      e.data = job_result(8'h11, 1, 1'b0, 1);
      e.id = IDW'(0);
      e.due = cyc + 1;
      sb.push_back(e);
      m_last = 0;
      m_busy = 1'b1;
    end
    repeat (600) cycle_step(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rot_sched.md
# rot_sched

Time-shares one external combinational 8-bit barrel rotator among NREQ requesters. It accepts rotate jobs (data, amount, direction, repeat count) through per-requester valid/ready ports, arbitrates round-robin, and iterates the rotator once per cycle for the requested number of passes. It returns the result with the requester ID on a single valid/ready response port. It sits between client engines (LED pattern, CRC/scramble helpers) and the shared rotator datapath.

## Interface
- NREQ, 4, number of requesters (2..4)
- IDW, 2, width of resp_id; NREQ <= 2**IDW
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  job offered by requester i
- req_ready  output  NREQ  one-hot grant; job i transfers on an edge where req_valid[i] & req_ready[i]
- req_data  input  8*NREQ  operand, bits [8i+7:8i] for requester i
- req_ctr  input  3*NREQ  rotate amount per pass, 0..7
- req_dir  input  NREQ  0 = rotate right, 1 = rotate left
- req_steps  input  4*NREQ  number of rotator passes, 0..15
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  8  rotated result
- resp_id  output  IDW  index of requester that owns the result
- busy  output  1  high in any state other than IDLE
- rot_data  output  8  operand to shared rotator
- rot_ctr  output  3  amount to shared rotator
- rot_dir  output  1  direction to shared rotator
- rot_out  input  8  rotator result, combinational from rot_data/rot_ctr/rot_dir, settles within one cycle

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Rotator semantics: dir 0 is out = data rotated right by ctr; dir 1 is rotate left by ctr. Net effect of a job = rotation by (steps*ctr) mod 8 in direction dir.
- IDLE: req_ready is combinational. It is one-hot on the winning requester when any req_valid is high, and all zero otherwise. Winner = first valid index searching from (last+1) mod NREQ upward with wrap. last = index of previous grant; resets to NREQ-1, so requester 0 has first priority.
- On transfer, in a single edge:
  - work <= data
  - ctr_r <= ctr, dir_r <= dir
  - cnt <= steps
  - id_r <= index, last <= index
  - Next state: RUN if steps != 0, else DONE.
- RUN: rot_data = work, rot_ctr = ctr_r, rot_dir = dir_r. All three are direct register outputs.
- Each RUN edge: work <= rot_out, cnt <= cnt-1. On the edge where cnt == 1 the state goes to DONE.
- DONE: resp_valid = 1, resp_data = work, resp_id = id_r.
  - Held stable while resp_ready = 0.
  - The edge with resp_ready = 1 goes to IDLE.
  - req_ready is all zero outside IDLE.
- req_valid deasserted before transfer is legal; the arbiter simply re-evaluates every IDLE cycle.
- Reset, at any time including mid-RUN or mid-DONE: the job is abandoned with no response. All registers clear.

## Timing
- Reset values:
  - state IDLE, req_ready 0, resp_valid 0, busy 0
  - resp_data 0x00, resp_id 0
  - rot_data 0x00, rot_ctr 0, rot_dir 0
  - last = NREQ-1
- Latency from transfer edge E0 to first resp_valid cycle: steps+1 cycles. For steps = 0, resp_valid is high in the cycle right after E0.
- Throughput: one job per steps+2 cycles at best. A new transfer can occur at the earliest in the cycle after the response handshake edge, since IDLE lasts at least one cycle.
- rot_* hold their last values outside RUN; only RUN cycles are meaningful to the rotator.
- busy = (state != IDLE), registered with the state.

## Test plan
- Req 1: data 0x01, ctr 2, dir 0, steps 1 -> resp_data 0x40, resp_id 1, resp_valid 2 cycles after transfer.
- Req 0: data 0x81, ctr 1, dir 1, steps 3 -> RUN for 3 cycles with rot_data sequence 0x81, 0x03, 0x06 -> resp_data 0x0C.
- Req 2: data 0xA5, steps 0, ctr 5 -> resp_data 0xA5, resp_id 2 in the cycle after transfer, no RUN cycles.
- All four req_valid held high from reset, each with steps 1 and resp_ready tied 1 -> grants in order 0,1,2,3,0. Then drop req 1 only -> next grants 2,3,0,2 (skip 1).
- resp_ready low for 5 cycles in DONE -> resp_valid, resp_data, resp_id stable; req_ready all zero despite pending valids; transfer occurs only after resp_ready rises.
- rst_n pulsed low during RUN of a steps-15 job -> all outputs at reset values immediately, no response. After release, requester 0 wins a simultaneous 0/3 request.
